eth_rx_frame_filter: RTL
========================

// Module: eth_rx_frame_filter
// PURPOSE
// Store-and-forward receive filter placed between the RMII MAC receive stream (rx_maxis_*) and
// the EthernetSystem input stream (in_*). It buffers each whole frame and checks its CRC-32 FCS,
// length and MAC error flag. It forwards only good frames, with the 4-byte FCS removed, and
// silently discards bad frames, so downstream logic never sees a partial or corrupt frame.
// PARAMETERS
// BUFFER_DEPTH     2048  data RAM bytes; power of 2, >= MAX_FRAME_BYTES
// LEN_FIFO_DEPTH   8     committed-frame length FIFO entries; power of 2
// MIN_FRAME_BYTES  64    minimum accepted frame length incl. FCS; shorter = runt, dropped
// MAX_FRAME_BYTES  1518  maximum accepted frame length incl. FCS; longer = giant, dropped
// PORTS
// clock              in   1   single clock for all logic
// aresetn            in   1   asynchronous active-low reset
// in_tdata           in   8   received byte; frame = preamble-stripped header..FCS
// in_tvalid          in   1   byte valid
// in_tready          out  1   0 while in reset, 1 otherwise; never backpressures the MAC
// in_tlast           in   1   last byte (final FCS byte) of frame
// in_tuser           in   1   MAC error flag; sampled only on the in_tlast beat
// out_tdata          out  8   forwarded byte
// out_tvalid         out  1   forwarded byte valid
// out_tready         in   1   downstream ready
// out_tlast          out  1   last payload byte (byte before the FCS)
// frames_ok_count    out  16  count of committed frames, wraps at 2^16
// frames_drop_count  out  16  count of dropped frames, wraps at 2^16
// drop_pulse         out  1   one-cycle pulse when a frame is dropped
// BEHAVIOUR
// - Reset values: all pointers, counters and FIFOs are 0. out_tvalid, out_tlast, drop_pulse = 0.
//   in_tready = 0 during reset. An in-flight input frame or output frame is abandoned on reset.
// - Input beat = in_tvalid & in_tready. Gaps in in_tvalid within a frame are legal.
// - Write side tracks wr_ptr, commit_ptr (start of current frame), byte count and a CRC register.
//   Pointers are log2(BUFFER_DEPTH)+1 bits wide; free = BUFFER_DEPTH - (wr_ptr - rd_ptr).
// - CRC-32 is reflected, poly 0xEDB88320, initialised to 0xFFFFFFFF at frame start and updated
//   every beat over all bytes including the FCS. A frame is good iff the register equals
//   0xDEBB20E3 after the tlast byte.
// - Write FSM states: IDLE -> RECV on the first beat. RECV -> DISCARD on overflow (free==0 on a
//   beat) or when the byte count exceeds MAX_FRAME_BYTES; no further bytes are written after
//   that. RECV/DISCARD -> IDLE on the tlast beat.
// - At tlast the frame is committed iff: FSM is in RECV, in_tuser==0, CRC is good,
//   count >= MIN_FRAME_BYTES, and the length FIFO is not full.
//   - Commit: push len = count-4 into the length FIFO; commit_ptr <= commit_ptr + len;
//     wr_ptr <= the same value, which reclaims the 4 FCS bytes; frames_ok_count++.
//   - Otherwise: wr_ptr <= commit_ptr, drop_pulse = 1 for the next cycle, frames_drop_count++.
// - A beat that is simultaneously the first and the last beat is a 1-byte runt and is dropped.
// - Read FSM states: IDLE -> LOAD when the length FIFO is non-empty. LOAD pops the length and
//   issues the first synchronous RAM read. LOAD -> SEND. SEND -> IDLE after the beat with
//   out_tlast & out_tready.
//   - out_tvalid rises no later than 3 cycles after the commit cycle when the read side is idle.
//   - out_tlast is asserted on byte len-1.
//   - While out_tvalid & !out_tready, out_tdata and out_tlast hold stable.
//   - With out_tready held high, throughput is 1 byte/cycle with no intra-frame bubbles.
// - rd_ptr advances on each output beat; freed space becomes visible to the write side the next
//   cycle. A commit and an output beat/pop in the same cycle are both honoured.
// - Frames leave in arrival order. Dropped frames never occupy length FIFO entries.
// TESTING
// - 64-byte frame with valid FCS, tuser=0, out_tready=1 -> 60 bytes out identical to the
//   input's first 60, tlast on the 60th, frames_ok_count=1.
// - Same frame with one payload bit flipped -> no output, drop_pulse once,
//   frames_drop_count=1, wr_ptr back to 0.
// - Good 60-byte frame incl. FCS (runt); separately, good frame with tuser=1 on tlast ->
//   each dropped, frames_drop_count increments by 1 for each.
// - Three back-to-back good 100-byte frames with out_tready toggling 1/0 every cycle ->
//   three 96-byte frames in order, with data held stable during stalls.
// - out_tready=0 while sending good 1518-byte frames until the buffer fills -> the frame that
//   overflows is dropped and earlier frames are intact. Then raise out_tready: the next good
//   frame is accepted once space exists.
// - aresetn pulled low mid-input-frame and mid-output-frame -> outputs go to reset values
//   immediately; after release a new good frame passes with frames_ok_count=1.

Source files
------------

// File: rtl/eth_rx_frame_filter.sv
// Store-and-forward receive filter: buffers each frame, checks FCS, length and MAC error,
// forwards good frames without the FCS and silently drops everything else.
module eth_rx_frame_filter #(
    parameter int BUFFER_DEPTH    = 2048,
    parameter int LEN_FIFO_DEPTH  = 8,
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1518
) (
    input  logic        clock,
    input  logic        aresetn,
    input  logic [7:0]  in_tdata,
    input  logic        in_tvalid,
    output logic        in_tready,
    input  logic        in_tlast,
    input  logic        in_tuser,
    output logic [7:0]  out_tdata,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic        out_tlast,
    output logic [15:0] frames_ok_count,
    output logic [15:0] frames_drop_count,
    output logic        drop_pulse
);

    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = 16;
    localparam int FA = $clog2(LEN_FIFO_DEPTH);
    localparam int FW = FA + 1;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {W_IDLE, W_RECV, W_DISCARD} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SEND} rstate_t;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    wstate_t        wstate, wstate_next;
    rstate_t        rstate, rstate_next;
    logic           ready_q;
    logic [PW-1:0]  wr_ptr, commit_ptr, rd_ptr, used, free;
    logic [LW-1:0]  byte_cnt, cnt_next, frame_len, rem;
    logic [31:0]    crc_q, crc_next;
    logic           beat, overflow, too_long, wr_en, do_commit, do_drop;
    logic [7:0]     mem [BUFFER_DEPTH];
    logic [7:0]     ram_q;
    logic [AW-1:0]  rd_addr;
    logic [LW-1:0]  lf_mem [LEN_FIFO_DEPTH];
    logic [FW-1:0]  lf_wp, lf_rp, lf_count;
    logic           lf_full, lf_empty, lf_pop, out_beat;

    assign in_tready = ready_q;
    assign beat      = in_tvalid & ready_q;
    assign used      = wr_ptr - rd_ptr;
    assign free      = PW'(BUFFER_DEPTH) - used;
    assign overflow  = (free == '0);
    assign cnt_next  = (wstate == W_IDLE) ? LW'(1) : byte_cnt + LW'(1);
    assign too_long  = cnt_next > LW'(MAX_FRAME_BYTES);
    assign crc_next  = crc_byte((wstate == W_IDLE) ? 32'hFFFFFFFF : crc_q, in_tdata);
    assign frame_len = cnt_next - LW'(4);
    assign lf_count  = lf_wp - lf_rp;
    assign lf_full   = (lf_count == FW'(LEN_FIFO_DEPTH));
    assign lf_empty  = (lf_wp == lf_rp);

    // ---------------- write side FSM ----------------
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) wstate <= W_IDLE;
        else          wstate <= wstate_next;
    end

    always_comb begin
        wstate_next = wstate;
        if (beat) begin
            if (in_tlast)
                wstate_next = W_IDLE;
            else if (wstate == W_DISCARD || overflow || too_long)
                wstate_next = W_DISCARD;
            else
                wstate_next = W_RECV;
        end
    end

    always_comb begin
        wr_en     = 1'b0;
        do_commit = 1'b0;
        do_drop   = 1'b0;
        if (beat && wstate != W_DISCARD)
            wr_en = !overflow && !too_long;
        if (beat && in_tlast) begin
            // A first-and-last beat arrives in W_IDLE and falls through to the drop path.
            if (wstate == W_RECV && wr_en && !in_tuser && crc_next == CRC_RESIDUE &&
                cnt_next >= LW'(MIN_FRAME_BYTES) && !lf_full)
                do_commit = 1'b1;
            else
                do_drop = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            ready_q           <= 1'b0;
            wr_ptr            <= '0;
            commit_ptr        <= '0;
            byte_cnt          <= '0;
            crc_q             <= '0;
            drop_pulse        <= 1'b0;
            frames_ok_count   <= '0;
            frames_drop_count <= '0;
            lf_wp             <= '0;
        end else begin
            ready_q    <= 1'b1;
            drop_pulse <= do_drop;
            if (do_commit) begin
                // Rewinding to commit_ptr + len also reclaims the four FCS bytes.
                commit_ptr      <= commit_ptr + PW'(frame_len);
                wr_ptr          <= commit_ptr + PW'(frame_len);
                lf_wp           <= lf_wp + FW'(1);
                frames_ok_count <= frames_ok_count + 16'd1;
            end else if (do_drop) begin
                wr_ptr            <= commit_ptr;
                frames_drop_count <= frames_drop_count + 16'd1;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (beat && wstate != W_DISCARD) begin
                byte_cnt <= cnt_next;
                crc_q    <= crc_next;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_commit)
            lf_mem[lf_wp[FA-1:0]] <= frame_len;
    end

    // ---------------- frame buffer RAM ----------------
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= in_tdata;
        ram_q <= mem[rd_addr];
    end

    // ---------------- read side FSM ----------------
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) rstate <= R_IDLE;
        else          rstate <= rstate_next;
    end

    always_comb begin
        rstate_next = rstate;
        case (rstate)
            R_IDLE:  if (!lf_empty) rstate_next = R_LOAD;
            R_LOAD:  rstate_next = R_SEND;
            R_SEND:  if (out_tready && rem == LW'(1)) rstate_next = R_IDLE;
            default: rstate_next = R_IDLE;
        endcase
    end

    // Re-reading rd_ptr while stalled keeps out_tdata stable; a beat prefetches the next byte.
    always_comb begin
        out_tvalid = (rstate == R_SEND);
        out_tlast  = out_tvalid && (rem == LW'(1));
        out_beat   = out_tvalid && out_tready;
        lf_pop     = (rstate == R_LOAD);
        rd_addr    = out_beat ? rd_ptr[AW-1:0] + AW'(1) : rd_ptr[AW-1:0];
    end

    assign out_tdata = ram_q;

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            rd_ptr <= '0;
            rem    <= '0;
            lf_rp  <= '0;
        end else begin
            if (lf_pop) begin
                rem   <= lf_mem[lf_rp[FA-1:0]];
                lf_rp <= lf_rp + FW'(1);
            end else if (out_beat) begin
                rem <= rem - LW'(1);
            end
            if (out_beat)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

endmodule
